// File: rtl/kgp_mem_pkg.sv
// Shared types for the data-memory port arbiter: width defaults, FSM states and owner IDs.
package kgp_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } arb_state_e;

    typedef enum logic {
        OwnCpu,
        OwnDbg
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-requester picker. MEM_ARB_RR_EN selects round-robin tie-break on
// i_last_owner; without it the CPU always wins a tie.
module arb_pick
    import kgp_mem_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_dbg_req,
`ifdef MEM_ARB_RR_EN
    input  owner_e i_last_owner,
`endif
    output owner_e o_winner
);

    always_comb begin
        o_winner = OwnCpu;
        if (i_cpu_req && i_dbg_req) begin
`ifdef MEM_ARB_RR_EN
            // The port that lost the previous tie (or was idle) goes first.
            o_winner = (i_last_owner == OwnCpu) ? OwnDbg : OwnCpu;
`else
            o_winner = OwnCpu;
`endif
        end else if (i_dbg_req) begin
            o_winner = OwnDbg;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU and debug ports, one access at a time.
// MEM_ARB_RR_EN enables the last_owner round-robin tie-break (default: fixed CPU priority).
module mem_port_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,

    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,

    output logic [DATA_W-1:0] o_rdata,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,

    output logic              o_busy
);

    arb_state_e        r_state;
    owner_e            r_owner;
    owner_e            w_winner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_we;
    logic              r_cpu_gnt;
    logic              r_dbg_gnt;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
`ifdef MEM_ARB_RR_EN
    owner_e            r_last_owner;
`endif

    arb_pick u_arb_pick (
        .i_cpu_req    (i_cpu_req),
        .i_dbg_req    (i_dbg_req),
`ifdef MEM_ARB_RR_EN
        .i_last_owner (r_last_owner),
`endif
        .o_winner     (w_winner)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_owner      <= OwnCpu;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_we     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= OwnDbg;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cpu_req || i_dbg_req) begin
                        r_state <= StAccess;
                        r_owner <= w_winner;
`ifdef MEM_ARB_RR_EN
                        r_last_owner <= w_winner;
`endif
                        if (w_winner == OwnCpu) begin
                            r_mem_we   <= i_cpu_we;
                            r_mem_addr <= i_cpu_addr;
                            r_mem_din  <= i_cpu_wdata;
                            r_cpu_gnt  <= 1'b1;
                        end else begin
                            r_mem_we   <= i_dbg_we;
                            r_mem_addr <= i_dbg_addr;
                            r_mem_din  <= i_dbg_wdata;
                            r_dbg_gnt  <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    r_cpu_gnt <= 1'b0;
                    r_dbg_gnt <= 1'b0;
                    r_mem_we  <= 1'b0;
                    if (r_mem_we) begin
                        r_state <= StIdle;
                    end else begin
                        // Memory samples the address on this edge; data is ready next cycle.
                        r_state      <= StResp;
                        r_cpu_rvalid <= (r_owner == OwnCpu);
                        r_dbg_rvalid <= (r_owner == OwnDbg);
                    end
                end
                StResp: begin
                    r_cpu_rvalid <= 1'b0;
                    r_dbg_rvalid <= 1'b0;
                    r_state      <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cpu_gnt    = r_cpu_gnt;
    assign o_dbg_gnt    = r_dbg_gnt;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_rdata      = i_mem_dout;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_we     = r_mem_we;
    assign o_mem_din    = r_mem_din;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 32x256 data memory between the CPU load/store stage and a debug/loader port. Accepts one access at a time from either requester, drives the memory address, write-enable and write-data lines, and returns read data with a valid strobe. It sits between the processor's execute/memory stage and the data-memory instance. The processor's counter sequencer waits on `cpu_rvalid` or `cpu_gnt` instead of fixed cycle counts.

## Interface
- `ADDR_W`, 8, memory word-address width
- `DATA_W`, 32, data width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_gnt`  out  1  one-cycle grant pulse
- `cpu_rvalid`  out  1  CPU read data valid, one cycle
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`: debug port, same widths and rules as the CPU port
- `rdata`  out  DATA_W  read data, shared by both ports, qualified by the rvalid strobes
- `mem_addr`  out  ADDR_W  to memory `addra`
- `mem_we`  out  1  to memory `wea`
- `mem_din`  out  DATA_W  to memory `dina`
- `mem_dout`  in  DATA_W  from memory `douta`; valid one cycle after the address is sampled
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Samples `cpu_req` and `dbg_req`.
  - If neither is high, stays in IDLE.
  - If either is high, picks a winner and latches the winner's `we`, `addr` and `wdata` into the `mem_*` registers and records the owner. Goes to ACCESS.
- **ACCESS**
  - `mem_addr`, `mem_din` and `mem_we` are driven from the latched values.
  - The owner's `gnt` is high for exactly this cycle.
  - Next state is RESP for a read, IDLE for a write.
- **RESP**
  - `rdata` = `mem_dout`; the owner's `rvalid` is high. Goes to IDLE.
- **Requests** are sampled only in IDLE. A requester must drop `req` on the edge after `gnt`; a `req` still high at the next IDLE is a new access.
- **Winner selection with both requesting:** decided by `last_owner`. The port that did not win last time wins. `last_owner` updates on every grant.
- **Single requester:** always wins, regardless of `last_owner`.
- **Idle outputs:** outside ACCESS, `mem_we` = 0 and `mem_addr`/`mem_din` hold their last values. `rdata` is don't-care outside RESP.
- **Reset values:** state = IDLE, `last_owner` = DBG (so the CPU wins the first tie). All `gnt`/`rvalid` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0, `busy` = 0.
- **Reset mid-access:** FSM returns to IDLE on that edge. A pending `rvalid` is never issued, and no further write is issued after that edge.
- **Widths:** no address arithmetic; addresses pass through unchanged. Accesses wrap naturally at 255.

## Timing
- Request seen in cycle N (IDLE) → `gnt` and `mem_*` valid in N+1.
- Write: committed at the edge ending N+1; next request can be sampled in N+2.
- Read: `mem_dout` sampled by the memory at the edge ending N+1; `rvalid`/`rdata` in N+2; next sample in N+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Fairness under continuous contention: the two ports alternate grants, so no port waits more than one foreign access.

## Configuration
- `MEM_ARB_RR_EN`
  - Defined: the `last_owner` round-robin tie-break described above.
  - Undefined: fixed priority; the CPU always wins a tie. `last_owner` is not implemented and the debug port can starve.

## Structure
- Package `kgp_mem_pkg`:
  - `ADDR_W`/`DATA_W` defaults
  - state enum: IDLE, ACCESS, RESP
  - owner enum: CPU, DBG
- Sub-module `arb_pick`: combinational two-requester picker. Inputs are both `req`s and `last_owner`; output is the winner. It holds the `MEM_ARB_RR_EN` switch.
- The FSM and the registers live in the top module.

## Test plan
- CPU write addr 0x10 data 0xDEADBEEF, then CPU read 0x10 → `cpu_gnt` in N+1 with `mem_we` = 1; `cpu_rvalid` in N+2 of the read with `rdata` = 0xDEADBEEF.
- CPU and debug both request in the same cycle after reset (write 0x01 and write 0x02, both to addr 0x20) → CPU granted first, debug next. A read of 0x20 returns 0x02.
- Both requests held continuously for 6 accesses, with `MEM_ARB_RR_EN` defined → grants alternate CPU, DBG, CPU, … Undefined → all 6 go to the CPU.
- Debug read of 0xFF while the CPU requests in the RESP cycle → CPU request ignored until IDLE, then `cpu_gnt` follows; `dbg_rvalid` is high for one cycle only.
- `rst` asserted in the ACCESS cycle of a CPU read → no `cpu_rvalid`, state IDLE, all outputs at reset values on the next cycle.
- No requests for 10 cycles → `busy`, `mem_we`, all `gnt`/`rvalid` stay 0.
